// File: rtl/avalon_slave_interface.sv
// -----------------------------------------------------------------------------
// avalon_slave_interface
//
// Avalon-MM burst slave that turns bursts from an external Avalon master into
// transactions on the AXI-like user bus (aw/w/ar/r channels). One burst is
// carried at a time. There is no reorder buffering, and read data is returned
// through a register stage.
//
// Optional feature: define AVS_ERROR_CHECK_EN to build the sticky protocol
// error detector. When the macro is not defined, error is tied to 0.
//
// Parameters
//   C_AVS_ADDR_WIDTH : byte address width on both sides
//   C_AVS_DATA_WIDTH : data width (byte lanes = C_AVS_DATA_WIDTH/8)
//   C_AVS_OFFSET     : added to the Avalon address to form awaddr/araddr
//
// Ports
//   ACLK, ARESETN       : clock, asynchronous active-low reset
//   avs_*               : Avalon-MM slave side (address, burstcount,
//                         byteenable, read, write, writedata, waitrequest,
//                         readdata, readdatavalid)
//   awaddr/awlen/awvalid/awready         : user write address channel
//   wdata/wstrb/wlast/wvalid/wready      : user write data channel
//   araddr/arlen/arvalid/arready         : user read address channel
//   rdata/rlast/rvalid/rready            : user read data channel
//   error               : sticky protocol error flag
// -----------------------------------------------------------------------------
module avalon_slave_interface #(
    parameter int                          C_AVS_ADDR_WIDTH = 32,
    parameter int                          C_AVS_DATA_WIDTH = 32,
    parameter logic [C_AVS_ADDR_WIDTH-1:0] C_AVS_OFFSET     = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    // Avalon-MM slave
    input  logic [C_AVS_ADDR_WIDTH-1:0]   avs_address,
    input  logic [8:0]                    avs_burstcount,
    input  logic [C_AVS_DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [C_AVS_DATA_WIDTH-1:0]   avs_writedata,
    output logic                          avs_waitrequest,
    output logic [C_AVS_DATA_WIDTH-1:0]   avs_readdata,
    output logic                          avs_readdatavalid,
    // user write address
    output logic [C_AVS_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                    awlen,
    output logic                          awvalid,
    input  logic                          awready,
    // user write data
    output logic [C_AVS_DATA_WIDTH-1:0]   wdata,
    output logic [C_AVS_DATA_WIDTH/8-1:0] wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    // user read address
    output logic [C_AVS_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                    arlen,
    output logic                          arvalid,
    input  logic                          arready,
    // user read data
    input  logic [C_AVS_DATA_WIDTH-1:0]   rdata,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    // status
    output logic                          error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic [C_AVS_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                    len_q, len_d;
    logic [8:0]                    count_q, count_d;
    logic [C_AVS_DATA_WIDTH-1:0]   rdata_q;
    logic                          rdv_q;

    logic [8:0]                    bc_eff_s;
    logic [8:0]                    bc_m1_s;
    logic                          waitreq_s;
    logic                          awvalid_s;
    logic                          wvalid_s;
    logic                          wlast_s;
    logic                          arvalid_s;
    logic                          rready_s;

    // Clamp burstcount into 1..256: zero becomes a single beat, oversize clips.
    always_comb begin
        bc_eff_s = avs_burstcount;
        if (avs_burstcount == 9'd0) begin
            bc_eff_s = 9'd1;
        end else if (avs_burstcount > 9'd256) begin
            bc_eff_s = 9'd256;
        end else begin
            bc_eff_s = avs_burstcount;
        end
        bc_m1_s = bc_eff_s - 9'd1;
    end

    // Next-state and handshake outputs for the burst FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        count_d   = count_q;
        waitreq_s = 1'b1;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        wlast_s   = 1'b0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // Write has priority when both requests are present.
                if (avs_write) begin
                    addr_d  = avs_address + C_AVS_OFFSET;
                    len_d   = bc_m1_s[7:0];
                    count_d = bc_eff_s;
                    state_d = WADDR;
                end else if (avs_read) begin
                    addr_d  = avs_address + C_AVS_OFFSET;
                    len_d   = bc_m1_s[7:0];
                    count_d = bc_eff_s;
                    state_d = RADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WADDR: begin
                awvalid_s = 1'b1;
                if (awready) begin
                    state_d = WDATA;
                end else begin
                    state_d = WADDR;
                end
            end
            WDATA: begin
                // Avalon beats flow straight through; wready is the stall.
                wvalid_s  = avs_write;
                waitreq_s = ~wready;
                wlast_s   = (count_q == 9'd1);
                if (avs_write && wready) begin
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WDATA;
                    end
                end else begin
                    state_d = WDATA;
                end
            end
            RADDR: begin
                // Release the Avalon command in the same cycle as the ar handshake.
                arvalid_s = 1'b1;
                waitreq_s = ~arready;
                if (arready) begin
                    state_d = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                // Termination uses the beat count only; rlast is not trusted.
                rready_s = 1'b1;
                if (rvalid) begin
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and captured burst command.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            count_q <= 9'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    // Register each accepted read beat so that it reaches Avalon one cycle later.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else if ((state_q == RDATA) && rvalid) begin
            rdata_q <= rdata;
            rdv_q   <= 1'b1;
        end else begin
            rdv_q   <= 1'b0;
        end
    end

`ifdef AVS_ERROR_CHECK_EN
    logic error_q;
    logic err_set_s;

    // Collect every protocol violation seen this cycle.
    always_comb begin
        err_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if ((avs_read || avs_write) &&
                    ((avs_burstcount == 9'd0) || (avs_burstcount > 9'd256))) begin
                    err_set_s = 1'b1;
                end else if (avs_read && avs_write) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end
            WDATA: begin
                err_set_s = avs_read;
            end
            RDATA: begin
                if (rvalid && (rlast != (count_q == 9'd1))) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end
            default: begin
                err_set_s = 1'b0;
            end
        endcase
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            error_q <= 1'b0;
        end else if (err_set_s) begin
            error_q <= 1'b1;
        end else begin
            error_q <= error_q;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign avs_waitrequest   = waitreq_s;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign awaddr            = addr_q;
    assign awlen             = len_q;
    assign awvalid           = awvalid_s;
    assign wdata             = avs_writedata;
    assign wstrb             = avs_byteenable;
    assign wlast             = wlast_s;
    assign wvalid            = wvalid_s;
    assign araddr            = addr_q;
    assign arlen             = len_q;
    assign arvalid           = arvalid_s;
    assign rready            = rready_s;

endmodule

// File: tb/tb_avalon_slave_interface.sv
module tb_avalon_slave_interface;

    localparam logic [31:0] OFF = 32'h0000_1000;
`ifdef AVS_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] avs_address;
    logic [8:0]  avs_burstcount;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        error;

    int total = 0;
    int bad   = 0;
    bit err_exp = 1'b0;

    avalon_slave_interface #(
        .C_AVS_ADDR_WIDTH(32),
        .C_AVS_DATA_WIDTH(32),
        .C_AVS_OFFSET(OFF)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .avs_address(avs_address), .avs_burstcount(avs_burstcount),
        .avs_byteenable(avs_byteenable), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .error(error)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Beats actually transferred for a requested burstcount.
    function automatic int eff(input int bc);
        if (bc == 0) return 1;
        if (bc > 256) return 256;
        return bc;
    endfunction

    // One write burst; abort_after>0 returns mid-burst after that many beats.
    task automatic do_write(input logic [31:0] addr, input int bc, input int awdly,
                            input int abort_after, input bit with_read);
        int n;
        int i;
        int cyc;
        logic [31:0] ea;
        logic [31:0] d[$];
        logic [3:0]  be[$];
        n  = eff(bc);
        ea = addr + OFF;
        for (int k = 0; k < n; k++) begin
            d.push_back($urandom);
            be.push_back(4'($urandom_range(0, 15)));
        end
        @(negedge ACLK);
        avs_write = 1'b1; avs_read = with_read; avs_address = addr;
        avs_burstcount = 9'(bc); avs_writedata = d[0]; avs_byteenable = be[0];
        awready = 1'b0; wready = 1'b0;
        #1;
        chk("w_idle_wait", avs_waitrequest, 1);
        chk("w_idle_awvalid", awvalid, 0);
        if (ERR_EN && (bc == 0 || bc > 256 || with_read)) err_exp = 1'b1;
        for (int c = 0; c < awdly; c++) begin
            @(negedge ACLK); awready = 1'b0; #1;
            chk("waddr_awvalid", awvalid, 1);
            chk("waddr_awaddr", awaddr, ea);
            chk("waddr_awlen", awlen, n - 1);
            chk("waddr_wait", avs_waitrequest, 1);
            chk("waddr_arvalid", arvalid, 0);
            chk("waddr_wvalid", wvalid, 0);
        end
        @(negedge ACLK); awready = 1'b1; #1;
        chk("waddr_hs_awvalid", awvalid, 1);
        chk("waddr_hs_awaddr", awaddr, ea);
        chk("waddr_hs_wait", avs_waitrequest, 1);
        i = 0; cyc = 0;
        while (i < n && cyc < 1000) begin
            @(negedge ACLK);
            awready = 1'b0;
            if (abort_after > 0 && i == abort_after) break;
            wready = 1'($urandom_range(0, 1));
            avs_writedata = d[i]; avs_byteenable = be[i];
            #1;
            chk("wdata_wvalid", wvalid, 1);
            chk("wdata_wdata", wdata, d[i]);
            chk("wdata_wstrb", wstrb, be[i]);
            chk("wdata_wlast", wlast, (i == n - 1));
            chk("wdata_wait", avs_waitrequest, !wready);
            chk("wdata_rready", rready, 0);
            chk("wdata_awvalid", awvalid, 0);
            if (wready) i++;
            cyc++;
        end
        if (abort_after == 0) begin
            chk("w_beats", i, n);
            @(negedge ACLK);
            avs_write = 1'b0; avs_read = 1'b0; wready = 1'b0;
            #1;
            chk("w_end_wait", avs_waitrequest, 1);
            chk("w_end_wvalid", wvalid, 0);
            chk("w_end_error", error, err_exp);
        end
    endtask

    // One read burst with random arready delay and random rvalid gaps.
    task automatic do_read(input logic [31:0] addr, input int bc, input int ardly);
        int n;
        int k;
        int j;
        int cyc;
        bit prev;
        logic [31:0] ea;
        logic [31:0] rd[$];
        n  = eff(bc);
        ea = addr + OFF;
        for (int m = 0; m < n; m++) rd.push_back($urandom);
        @(negedge ACLK);
        avs_read = 1'b1; avs_write = 1'b0; avs_address = addr;
        avs_burstcount = 9'(bc); arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("r_idle_wait", avs_waitrequest, 1);
        chk("r_idle_arvalid", arvalid, 0);
        if (ERR_EN && (bc == 0 || bc > 256)) err_exp = 1'b1;
        for (int c = 0; c < ardly; c++) begin
            @(negedge ACLK); arready = 1'b0; #1;
            chk("raddr_arvalid", arvalid, 1);
            chk("raddr_araddr", araddr, ea);
            chk("raddr_arlen", arlen, n - 1);
            chk("raddr_wait", avs_waitrequest, 1);
            chk("raddr_awvalid", awvalid, 0);
            chk("raddr_rready", rready, 0);
        end
        @(negedge ACLK); arready = 1'b1; #1;
        chk("raddr_hs_arvalid", arvalid, 1);
        chk("raddr_hs_araddr", araddr, ea);
        chk("raddr_hs_wait", avs_waitrequest, 0);
        k = 0; j = 0; cyc = 0; prev = 1'b0;
        while (j < n && cyc < 3000) begin
            @(negedge ACLK);
            avs_read = 1'b0; arready = 1'b0;
            if (prev) begin
                chk("rdv_pulse", avs_readdatavalid, 1);
                chk("rdata_order", avs_readdata, rd[j]);
                j++;
            end else begin
                chk("rdv_idle", avs_readdatavalid, 0);
            end
            if (k < n) begin
                rvalid = ($urandom_range(0, 2) != 0);
                rdata  = rvalid ? rd[k] : $urandom;
                rlast  = (k == n - 1);
                #1;
                chk("rdata_rready", rready, 1);
                chk("rdata_wait", avs_waitrequest, 1);
                prev = rvalid;
                if (rvalid) k++;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; prev = 1'b0;
                #1;
                chk("r_done_rready", rready, 0);
            end
            cyc++;
        end
        chk("r_beats", j, n);
        @(negedge ACLK); #1;
        chk("r_end_rdv", avs_readdatavalid, 0);
        chk("r_end_error", error, err_exp);
    endtask

    initial begin
        ARESETN = 1'b0;
        avs_address = 32'd0; avs_burstcount = 9'd0; avs_byteenable = 4'd0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
        #12;
        chk("rst_wait", avs_waitrequest, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rdv", avs_readdatavalid, 0);
        chk("rst_error", error, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_rready", rready, 0);
        @(negedge ACLK); ARESETN = 1'b1;

        // Single write, then a 4-beat write burst with wready stalls.
        do_write(32'h0000_0100, 1, 2, 0, 1'b0);
        do_write(32'h0000_0300, 4, 0, 0, 1'b0);
        // 8-beat read burst, arready on the third cycle.
        do_read(32'h0000_0040, 8, 2);

        // Random mix of bursts.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, $urandom_range(1, 16), $urandom_range(0, 3), 0, 1'b0);
            else
                do_read($urandom, $urandom_range(1, 16), $urandom_range(0, 3));
        end

        // Read and write together: the write goes first.
        do_write(32'h0000_0500, 3, 1, 0, 1'b1);
        do_read(32'h0000_0500, 2, 0);

        // Reset in the middle of a write burst, after 2 of 4 beats.
        do_write(32'h0000_0200, 4, 1, 2, 1'b0);
        ARESETN = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("midrst_awvalid", awvalid, 0);
        chk("midrst_wvalid", wvalid, 0);
        chk("midrst_wait", avs_waitrequest, 1);
        chk("midrst_error", error, 0);
        chk("midrst_awaddr", awaddr, 0);
        chk("midrst_arlen", arlen, 0);
        avs_write = 1'b0; wready = 1'b0;
        @(negedge ACLK); ARESETN = 1'b1;
        do_write(32'h0000_0600, 2, 1, 0, 1'b0);

        // Burstcount 0 read, then an oversize read with address wrap.
        do_read(32'h0000_0080, 0, 1);
        do_read(32'hFFFF_F800, 300, 0);
        do_write(32'h0000_0700, 5, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
